// File: rtl/keypad_scan_controller.sv
// 4x4 keypad column scanner with row synchroniser, press/release debounce and registered key code.
// Optional held-key auto-repeat is compiled in when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_scan_controller #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [3:0] rowIn,
  output logic [3:0] colDrive,
  output logic [7:0] eightBitButton,
  output logic       validPress,
  output logic       keyHeld
);

  localparam int MAX_AB = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int MAX_C  = (MAX_AB > REPEAT_CYCLES) ? MAX_AB : REPEAT_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] CNT_SAT   = {CW{1'b1}};
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  // Sample that enters DEBOUNCE/RELEASE is the first stable one, so acceptance fires one count early.
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 2);
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    sync1_q, row_sync_q;
  logic [3:0]    col_q, col_d;
  logic [3:0]    cap_q, cap_d;
  logic [7:0]    button_q, button_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;
  logic [CW-1:0] scan_cnt_q, scan_cnt_d;
  logic [CW-1:0] deb_cnt_q, deb_cnt_d;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [CW-1:0] rep_cnt_q, rep_cnt_d;
`endif

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_SAT) ? v : v + CW'(1);
  endfunction

  function automatic logic one_zero(input logic [3:0] r);
    return (r == 4'b1110) || (r == 4'b1101) || (r == 4'b1011) || (r == 4'b0111);
  endfunction

  // Next-state and next-output computation for the scan/debounce FSM.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    cap_d      = cap_q;
    button_d   = button_q;
    valid_d    = 1'b0;
    held_d     = held_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_cnt_d  = '0;
`endif
    case (state_q)
      SCAN: begin
        if (one_zero(row_sync_q)) begin
          state_d   = DEBOUNCE;
          deb_cnt_d = '0;
          cap_d     = row_sync_q;
        end else if (scan_cnt_q == SCAN_LAST) begin
          col_d      = {col_q[0], col_q[3:1]};
          scan_cnt_d = '0;
        end else begin
          scan_cnt_d = sat_inc(scan_cnt_q);
        end
      end
      DEBOUNCE: begin
        if (row_sync_q != cap_q) begin
          state_d    = SCAN;
          scan_cnt_d = '0;
          deb_cnt_d  = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = PRESSED;
          button_d  = {col_q, row_sync_q};
          valid_d   = 1'b1;
          held_d    = 1'b1;
          deb_cnt_d = sat_inc(deb_cnt_q);
        end else begin
          deb_cnt_d = sat_inc(deb_cnt_q);
        end
      end
      PRESSED: begin
        if (row_sync_q == 4'b1111) begin
          state_d   = RELEASE;
          deb_cnt_d = '0;
        end else begin
          state_d = PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
          if (rep_cnt_q == REP_LAST) begin
            valid_d   = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = sat_inc(rep_cnt_q);
          end
`endif
        end
      end
      RELEASE: begin
        if (row_sync_q != 4'b1111) begin
          state_d   = PRESSED;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          // Resume scanning on the column after the one that held the key.
          state_d    = SCAN;
          held_d     = 1'b0;
          col_d      = {col_q[0], col_q[3:1]};
          scan_cnt_d = '0;
          deb_cnt_d  = sat_inc(deb_cnt_q);
        end else begin
          deb_cnt_d = sat_inc(deb_cnt_q);
        end
      end
      default: begin
        state_d    = SCAN;
        col_d      = 4'b0111;
        held_d     = 1'b0;
        scan_cnt_d = '0;
        deb_cnt_d  = '0;
      end
    endcase
  end

  // State, synchroniser and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      sync1_q    <= 4'b1111;
      row_sync_q <= 4'b1111;
      state_q    <= SCAN;
      col_q      <= 4'b0111;
      cap_q      <= 4'b1111;
      button_q   <= 8'hFF;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_q  <= '0;
`endif
    end else begin
      sync1_q    <= rowIn;
      row_sync_q <= sync1_q;
      state_q    <= state_d;
      col_q      <= col_d;
      cap_q      <= cap_d;
      button_q   <= button_d;
      valid_q    <= valid_d;
      held_q     <= held_d;
      scan_cnt_q <= scan_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_q  <= rep_cnt_d;
`endif
    end
  end

  assign colDrive       = col_q;
  assign eightBitButton = button_q;
  assign validPress     = valid_q;
  assign keyHeld        = held_q;

endmodule
